// File: rtl/frame_bank_arbiter.sv
// frame_bank_arbiter: N clients share two frame banks through per-bank round-robin arbiters.
// Capture and display bank roles swap on each frame_flag rise.
module frame_bank_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 36,
    parameter int READ_LATENCY = 2,
    parameter logic [NUM_CLIENTS-1:0] CAPTURE_MASK = 'b0011
) (
    input  logic clock,
    input  logic reset,
    input  logic frame_flag,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
    output logic [NUM_CLIENTS-1:0] ack,
    output logic [NUM_CLIENTS-1:0] rvalid,
    output logic [NUM_CLIENTS*DATA_W-1:0] rdata,
    output logic capture_bank,
    output logic [ADDR_W-1:0] mem0_addr,
    output logic [ADDR_W-1:0] mem1_addr,
    output logic [DATA_W-1:0] mem0_write,
    output logic [DATA_W-1:0] mem1_write,
    output logic mem0_wr,
    output logic mem1_wr,
    input  logic [DATA_W-1:0] mem0_read,
    input  logic [DATA_W-1:0] mem1_read
);
    localparam int IW = $clog2(NUM_CLIENTS);
    localparam int L = READ_LATENCY;
    logic frame_q;
    logic [1:0] hit;
    logic [1:0] mwr;
    logic [IW-1:0] last [2];
    logic [IW-1:0] gid [2];
    logic [NUM_CLIENTS-1:0] cand [2];
    logic [ADDR_W-1:0] ma [2];
    logic [DATA_W-1:0] mw [2];
    logic [DATA_W-1:0] mr [2];
    logic [L:0] pv [2];
    logic [IW-1:0] pid [2][L+1];
    assign mem0_addr = ma[0];
    assign mem1_addr = ma[1];
    assign mem0_write = mw[0];
    assign mem1_write = mw[1];
    assign mem0_wr = mwr[0];
    assign mem1_wr = mwr[1];
    assign mr[0] = mem0_read;
    assign mr[1] = mem1_read;
    always_comb begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NUM_CLIENTS; i++)
                cand[b][i] = req[i] & ((CAPTURE_MASK[i] ? capture_bank : ~capture_bank) == 1'(b));
    end
    // Scan offsets from farthest to nearest so the client closest after last_grant wins.
    always_comb begin
        hit = '0;
        ack = '0;
        for (int b = 0; b < 2; b++) begin
            gid[b] = '0;
            for (int k = NUM_CLIENTS; k >= 1; k--)
                if (cand[b][(int'(last[b]) + k) % NUM_CLIENTS]) begin
                    hit[b] = 1'b1;
                    gid[b] = IW'((int'(last[b]) + k) % NUM_CLIENTS);
                end
            if (hit[b] && !reset) ack[gid[b]] = 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_q <= 1'b0;
            capture_bank <= 1'b0;
            rvalid <= '0;
            rdata <= '0;
            for (int b = 0; b < 2; b++) begin
                last[b] <= IW'(NUM_CLIENTS - 1);
                ma[b] <= '0;
                mw[b] <= '0;
                mwr[b] <= 1'b0;
                pv[b] <= '0;
                for (int k = 0; k <= L; k++) pid[b][k] <= '0;
            end
        end else begin
            frame_q <= frame_flag;
            if (frame_flag && !frame_q) capture_bank <= ~capture_bank;
            rvalid <= '0;
            for (int b = 0; b < 2; b++) begin
                mwr[b] <= hit[b] & wr[gid[b]];
                if (hit[b]) begin
                    last[b] <= gid[b];
                    ma[b] <= addr[gid[b]*ADDR_W +: ADDR_W];
                    mw[b] <= wdata[gid[b]*DATA_W +: DATA_W];
                end
                // Read tags travel with the bank, so a role swap never redirects in-flight data.
                pv[b] <= {pv[b][L-1:0], hit[b] & ~wr[gid[b]]};
                pid[b][0] <= gid[b];
                for (int k = 1; k <= L; k++) pid[b][k] <= pid[b][k-1];
                if (pv[b][L]) begin
                    rvalid[pid[b][L]] <= 1'b1;
                    rdata[pid[b][L]*DATA_W +: DATA_W] <= mr[b];
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_bank_arbiter.sv
// tb_frame_bank_arbiter: vector table plus read-return scoreboard for the default build,
// and a rotation/latency sequence for a 6-client, latency-3 build.
module tb_frame_bank_arbiter;
    localparam int AW = 19;
    localparam int DW = 36;
    localparam logic [3:0] MASK_A = 4'b0011;
    localparam int NR = 31;

    typedef struct {
        logic rst;
        logic ff;
        logic [3:0] req;
        logic [3:0] wr;
        logic [3:0] ack;
        logic cap;
    } vec_t;
    typedef struct {
        int id;
        int due;
        logic [DW-1:0] data;
    } sb_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic ff_a;
    logic [3:0] req_a, wr_a, ack_a, rv_a;
    logic [4*AW-1:0] addr_a;
    logic [4*DW-1:0] wd_a, rd_a;
    logic cap_a, m0a_wr, m1a_wr;
    logic [AW-1:0] m0a_addr, m1a_addr;
    logic [DW-1:0] m0a_wd, m1a_wd, m0a_rd, m1a_rd;

    logic ff_b = 1'b0;
    logic [5:0] req_b, wr_b, ack_b, rv_b;
    logic [6*AW-1:0] addr_b;
    logic [6*DW-1:0] wd_b, rd_b;
    logic cap_b, m0b_wr, m1b_wr;
    logic [AW-1:0] m0b_addr, m1b_addr;
    logic [DW-1:0] m0b_wd, m1b_wd, m0b_rd, m1b_rd;

    frame_bank_arbiter dut_a (
        .clock(clock), .reset(reset), .frame_flag(ff_a), .req(req_a), .wr(wr_a),
        .addr(addr_a), .wdata(wd_a), .ack(ack_a), .rvalid(rv_a), .rdata(rd_a),
        .capture_bank(cap_a), .mem0_addr(m0a_addr), .mem1_addr(m1a_addr),
        .mem0_write(m0a_wd), .mem1_write(m1a_wd), .mem0_wr(m0a_wr), .mem1_wr(m1a_wr),
        .mem0_read(m0a_rd), .mem1_read(m1a_rd)
    );

    frame_bank_arbiter #(.NUM_CLIENTS(6), .READ_LATENCY(3), .CAPTURE_MASK(6'b000111)) dut_b (
        .clock(clock), .reset(reset), .frame_flag(ff_b), .req(req_b), .wr(wr_b),
        .addr(addr_b), .wdata(wd_b), .ack(ack_b), .rvalid(rv_b), .rdata(rd_b),
        .capture_bank(cap_b), .mem0_addr(m0b_addr), .mem1_addr(m1b_addr),
        .mem0_write(m0b_wd), .mem1_write(m1b_wd), .mem0_wr(m0b_wr), .mem1_wr(m1b_wr),
        .mem0_read(m0b_rd), .mem1_read(m1b_rd)
    );

    function automatic logic [DW-1:0] g(input int b, input logic [AW-1:0] a);
        return (b != 0 ? 36'hA_0000_0000 : 36'h1_2345_6779) + DW'(a);
    endfunction
    function automatic logic [AW-1:0] adr(input int r, input int i);
        return AW'(r * 16 + i);
    endfunction
    function automatic logic [DW-1:0] wdt(input int r, input int i);
        return 36'h5_0000_0000 + DW'(r * 256 + i);
    endfunction

    // Bank memories: data follows the address cycle by the build's read latency.
    logic [AW-1:0] ha0 [2], ha1 [2], hb0 [3], hb1 [3];
    always @(posedge clock) begin
        ha0[0] <= m0a_addr; ha0[1] <= ha0[0];
        ha1[0] <= m1a_addr; ha1[1] <= ha1[0];
        hb0[0] <= m0b_addr; hb0[1] <= hb0[0]; hb0[2] <= hb0[1];
        hb1[0] <= m1b_addr; hb1[1] <= hb1[0]; hb1[2] <= hb1[1];
    end
    assign m0a_rd = g(0, ha0[1]);
    assign m1a_rd = g(1, ha1[1]);
    assign m0b_rd = g(0, hb0[2]);
    assign m1b_rd = g(1, hb1[2]);

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    vec_t tbl [NR];
    task automatic row(input int r, input logic rst, input logic ff, input logic [3:0] rq,
                       input logic [3:0] w, input logic [3:0] a);
        tbl[r].rst = rst; tbl[r].ff = ff; tbl[r].req = rq; tbl[r].wr = w; tbl[r].ack = a;
    endtask

    sb_t qa[$], qb[$];
    logic [AW-1:0] ex_addr [2];
    logic [DW-1:0] ex_wd [2];
    logic [1:0] ex_wr;
    logic [5:0] exp_rv;
    sb_t e;

    initial begin
        for (int r = 0; r < NR; r++) tbl[r] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, (r >= 16 && r <= 25)};
        row(1, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        row(6, 0, 0, 4'b0010, 4'b0010, 4'b0010);
        for (int r = 7; r <= 12; r++) row(r, 0, 0, 4'b0011, 4'b0011, (r % 2 != 0) ? 4'b0001 : 4'b0010);
        row(13, 0, 0, 4'b0101, 4'b0001, 4'b0101);
        row(15, 0, 1, 4'b0100, 4'b0000, 4'b0100);
        row(16, 0, 1, 4'b0100, 4'b0000, 4'b0100);
        row(17, 0, 1, 4'b0100, 4'b0000, 4'b0100);
        row(18, 0, 0, 4'b0100, 4'b0000, 4'b0100);
        row(23, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        row(25, 1, 0, 4'b0001, 4'b0000, 4'b0000);
        row(28, 0, 0, 4'b1111, 4'b1111, 4'b0101);

        ff_a = 0; req_a = 0; wr_a = 0; addr_a = '0; wd_a = '0;
        req_b = 0; wr_b = 0; addr_b = '0; wd_b = '0;
        for (int i = 0; i < 2; i++) begin ex_addr[i] = '0; ex_wd[i] = '0; end
        ex_wr = 2'b00;
        reset = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rdata_reset_zero", 64'(rd_a === '0), 1);
        chk("rvalid_reset", rv_a, 0);
        @(posedge clock); #1;

        for (int r = 0; r < NR; r++) begin
            reset = tbl[r].rst; ff_a = tbl[r].ff; req_a = tbl[r].req; wr_a = tbl[r].wr;
            for (int i = 0; i < 4; i++) begin
                addr_a[i*AW +: AW] = adr(r, i);
                wd_a[i*DW +: DW] = wdt(r, i);
            end
            @(negedge clock);
            chk($sformatf("ack r%0d", r), ack_a, tbl[r].ack);
            chk($sformatf("capture_bank r%0d", r), cap_a, tbl[r].cap);
            chk($sformatf("mem0_addr r%0d", r), m0a_addr, ex_addr[0]);
            chk($sformatf("mem1_addr r%0d", r), m1a_addr, ex_addr[1]);
            chk($sformatf("mem0_wr r%0d", r), m0a_wr, ex_wr[0]);
            chk($sformatf("mem1_wr r%0d", r), m1a_wr, ex_wr[1]);
            if (ex_wr[0]) chk($sformatf("mem0_write r%0d", r), m0a_wd, ex_wd[0]);
            if (ex_wr[1]) chk($sformatf("mem1_write r%0d", r), m1a_wd, ex_wd[1]);
            exp_rv = '0;
            while (qa.size() > 0 && qa[0].due == r) begin
                e = qa.pop_front();
                exp_rv[e.id] = 1'b1;
                chk($sformatf("rdata[%0d] r%0d", e.id, r), rd_a[e.id*DW +: DW], e.data);
            end
            chk($sformatf("rvalid r%0d", r), rv_a, exp_rv[3:0]);
            if (tbl[r].rst) begin
                for (int b = 0; b < 2; b++) begin ex_addr[b] = '0; ex_wd[b] = '0; end
                ex_wr = 2'b00;
                qa.delete();
            end else begin
                for (int b = 0; b < 2; b++) begin
                    ex_wr[b] = 1'b0;
                    for (int i = 0; i < 4; i++)
                        if (tbl[r].ack[i] && ((MASK_A[i] ? tbl[r].cap : ~tbl[r].cap) == 1'(b))) begin
                            ex_addr[b] = adr(r, i);
                            ex_wd[b] = wdt(r, i);
                            ex_wr[b] = tbl[r].wr[i];
                            if (!tbl[r].wr[i]) qa.push_back('{i, r + 4, g(b, adr(r, i))});
                        end
                end
            end
            @(posedge clock); #1;
        end

        reset = 1; req_a = 0; ff_a = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        for (int i = 0; i < 6; i++) addr_b[i*AW +: AW] = AW'(64 + i);
        for (int k = 0; k < 18; k++) begin
            req_b = (k < 12) ? 6'b111111 : 6'b000000;
            @(negedge clock);
            chk($sformatf("b ack k%0d", k), ack_b, (k < 12) ? ((1 << (k % 3)) | (8 << (k % 3))) : 0);
            exp_rv = '0;
            while (qb.size() > 0 && qb[0].due == k) begin
                e = qb.pop_front();
                exp_rv[e.id] = 1'b1;
                chk($sformatf("b rdata[%0d] k%0d", e.id, k), rd_b[e.id*DW +: DW], e.data);
            end
            chk($sformatf("b rvalid k%0d", k), rv_b, exp_rv);
            if (k < 12) begin
                qb.push_back('{k % 3, k + 5, g(0, AW'(64 + k % 3))});
                qb.push_back('{3 + k % 3, k + 5, g(1, AW'(67 + k % 3))});
            end
            @(posedge clock); #1;
        end
        chk("b capture_bank", cap_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_bank_arbiter.md
# frame_bank_arbiter

Parametrised N-client arbiter for the two ZBT frame banks, successor to the fixed four-client memory interface. It lets any number of pipeline stages (NTSC capture, filtering, projective transform, VGA readout, …) share mem0/mem1. Each client is statically mapped to either the "capture" bank or the "display" bank, and the two roles swap on every `frame_flag` rising edge. Each bank has its own round-robin arbiter with a pipelined read-return path, so clients on opposite banks never contend.

## Interface
- `NUM_CLIENTS`, 4: number of client ports, 2..8.
- `ADDR_W`, 19: memory word address width.
- `DATA_W`, 36: memory word width.
- `READ_LATENCY`, 2: cycles from the address cycle on `memN_addr` to valid data on `memN_read`, 1..4.
- `CAPTURE_MASK`, 4'b0011: bit i = 1 maps client i to the capture bank; bit i = 0 maps it to the display bank.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `frame_flag`  in  1  frame boundary; rising edge swaps bank roles.
- `req`  in  NUM_CLIENTS  per-client access request (level).
- `wr`  in  NUM_CLIENTS  per-client 1 = write, 0 = read; qualified by `req`.
- `addr`  in  NUM_CLIENTS*ADDR_W  packed addresses; client i in slice [i*ADDR_W +: ADDR_W].
- `wdata`  in  NUM_CLIENTS*DATA_W  packed write data.
- `ack`  out  NUM_CLIENTS  combinational grant; transfer occurs on an edge where `req[i] & ack[i]`.
- `rvalid`  out  NUM_CLIENTS  one-cycle read-return strobe.
- `rdata`  out  NUM_CLIENTS*DATA_W  packed read data; slice i valid while `rvalid[i]`.
- `capture_bank`  out  1  index of the bank currently in the capture role.
- `mem0_addr`, `mem1_addr`  out  ADDR_W  bank addresses.
- `mem0_write`, `mem1_write`  out  DATA_W  bank write data.
- `mem0_wr`, `mem1_wr`  out  1  bank write enables.
- `mem0_read`, `mem1_read`  in  DATA_W  bank read data.

## Operation
- Role mapping: a capture client targets bank `capture_bank`; a display client targets bank `~capture_bank`.
- Per-bank arbiter:
  - Candidates are clients with `req` high that map to that bank.
  - Round-robin search starts at `last_grant + 1` (mod NUM_CLIENTS).
  - At most one `ack` per bank per cycle, so up to two `ack` bits are high in a cycle.
  - `last_grant` updates only on a transfer.
- Issue: on a transfer edge the bank registers the client's addr and wdata, with `wr` driven to `memN_wr`.
  - No transfer: `memN_wr` = 0; addr and write data hold their last values.
- Read return:
  - Each bank has a shift pipeline of depth READ_LATENCY+1 holding {valid, client id}.
  - On exit, the pipeline captures `memN_read` into the client's `rdata` slice and pulses its `rvalid`.
  - The `rdata` slice holds its value until the next return to that client.
- Frame swap:
  - `frame_flag` is edge-detected against a registered copy. A held-high level swaps only once.
  - `capture_bank` toggles at the edge ending the cycle in which the rise is seen.
  - Requests in that same cycle arbitrate under the old mapping; the new mapping applies from the next cycle.
  - In-flight reads complete to their original client and bank regardless of the swap.
- Writes produce no `rvalid`. A client may issue back-to-back transfers, one per cycle.

## Timing
- Reset values:
  - `capture_bank` = 0; `last_grant` = NUM_CLIENTS-1 for both banks, so client 0 wins first.
  - `mem*_wr` = 0, `mem*_addr` = 0, `mem*_write` = 0.
  - `rvalid` = 0, `rdata` = 0; pipelines and frame-flag edge register cleared.
- `ack` is combinational from `req`, `capture_bank` and `last_grant`. It is 0 while `reset` is high.
- Transfer at edge E:
  - `memN_addr`, `memN_wr` and `memN_write` are valid in cycle E+1.
  - Read data sampled from `memN_read` in cycle E+1+READ_LATENCY.
  - `rvalid` and `rdata` asserted in cycle E+2+READ_LATENCY. With default latency 2: `rvalid` 4 cycles after the transfer edge.
- Reset mid-operation: the pipeline is flushed, so no `rvalid` appears for reads issued before reset. `capture_bank` returns to 0.
- Sustained throughput: one access per bank per cycle; a continuously requesting client gets at least 1 of every k grants, where k is the number of clients mapped to its bank.

## Test plan
- Reset, then client 0 (capture) reads addr 0x00010 with `mem0_read` returning 0x123456789 after 2 cycles. Required: `ack[0]` in the request cycle, `mem0_addr` = 0x00010 with `mem0_wr` = 0 in the next cycle, `rvalid[0]` with `rdata[0]` = 0x123456789 exactly 4 cycles after the transfer edge.
- Clients 0 and 1 both hold `req` as capture writes for 6 cycles. Required: grants alternate 0,1,0,1,0,1, `mem0_wr` is high every cycle, and `mem1` is untouched.
- Client 0 writes and client 2 reads in the same cycle. Required: both ack'd, `mem0_wr` = 1, `mem1_addr` = client 2's address, with no stall.
- `frame_flag` held high for 3 cycles while client 2 streams reads. Required: `capture_bank` toggles exactly once, and client 2's accesses move from mem1 to mem0 starting the cycle after the rise. Reads issued before the swap still return to client 2 from mem1 data.
- Assert `reset` for one cycle 2 cycles after a read transfer. Required: no `rvalid`; all memory outputs and `capture_bank` return to 0.
- Build with NUM_CLIENTS = 6, READ_LATENCY = 3, CAPTURE_MASK = 6'b000111, and all clients reading continuously. Required: each bank grants its 3 clients in rotation, and every `rvalid` arrives 5 cycles after its transfer edge.
